// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded dual-issue pair in, registered EX pair out.
// Pipeline control (flush, mem_stall) rides along with the pair it governs.
interface id_ex_if;
  logic        flush;
  logic        mem_stall;

  logic        ID_valid_a,    ID_valid_b;
  logic [31:0] ID_pc_a,       ID_pc_b;
  logic [4:0]  ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_raddr_b1, ID_rf_raddr_b2;
  logic [31:0] ID_rf_rdata_a1, ID_rf_rdata_a2, ID_rf_rdata_b1, ID_rf_rdata_b2;
  logic [4:0]  ID_rf_waddr_a, ID_rf_waddr_b;
  logic        ID_rf_we_a,    ID_rf_we_b;
  logic        ID_is_load_a,  ID_is_load_b;
  logic        ID_ready;

  logic        EX_valid_a,    EX_valid_b;
  logic [31:0] EX_pc_a,       EX_pc_b;
  logic [4:0]  EX_rf_raddr_a1, EX_rf_raddr_a2, EX_rf_raddr_b1, EX_rf_raddr_b2;
  logic [31:0] EX_rf_rdata_a1, EX_rf_rdata_a2, EX_rf_rdata_b1, EX_rf_rdata_b2;
  logic [4:0]  EX_rf_waddr_a, EX_rf_waddr_b;
  logic        EX_rf_we_a,    EX_rf_we_b;
  logic        EX_is_load_a,  EX_is_load_b;

  modport master (
    output flush, mem_stall,
    output ID_valid_a, ID_valid_b, ID_pc_a, ID_pc_b,
    output ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_raddr_b1, ID_rf_raddr_b2,
    output ID_rf_rdata_a1, ID_rf_rdata_a2, ID_rf_rdata_b1, ID_rf_rdata_b2,
    output ID_rf_waddr_a, ID_rf_waddr_b, ID_rf_we_a, ID_rf_we_b,
    output ID_is_load_a, ID_is_load_b,
    input  ID_ready,
    input  EX_valid_a, EX_valid_b, EX_pc_a, EX_pc_b,
    input  EX_rf_raddr_a1, EX_rf_raddr_a2, EX_rf_raddr_b1, EX_rf_raddr_b2,
    input  EX_rf_rdata_a1, EX_rf_rdata_a2, EX_rf_rdata_b1, EX_rf_rdata_b2,
    input  EX_rf_waddr_a, EX_rf_waddr_b, EX_rf_we_a, EX_rf_we_b,
    input  EX_is_load_a, EX_is_load_b
  );

  modport slave (
    input  flush, mem_stall,
    input  ID_valid_a, ID_valid_b, ID_pc_a, ID_pc_b,
    input  ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_raddr_b1, ID_rf_raddr_b2,
    input  ID_rf_rdata_a1, ID_rf_rdata_a2, ID_rf_rdata_b1, ID_rf_rdata_b2,
    input  ID_rf_waddr_a, ID_rf_waddr_b, ID_rf_we_a, ID_rf_we_b,
    input  ID_is_load_a, ID_is_load_b,
    output ID_ready,
    output EX_valid_a, EX_valid_b, EX_pc_a, EX_pc_b,
    output EX_rf_raddr_a1, EX_rf_raddr_a2, EX_rf_raddr_b1, EX_rf_raddr_b2,
    output EX_rf_rdata_a1, EX_rf_rdata_a2, EX_rf_rdata_b1, EX_rf_rdata_b2,
    output EX_rf_waddr_a, EX_rf_waddr_b, EX_rf_we_a, EX_rf_we_b,
    output EX_is_load_a, EX_is_load_b
  );
endinterface

// File: rtl/id_ex_stage.sv
// Dual-issue ID/EX pipeline register with load-use interlock and
// intra-pair dependency splitting (slot a first, slot b one cycle later).
module id_ex_stage (
  input  logic     clk,
  input  logic     rst,
  id_ex_if.slave   bus
);

  typedef enum logic {PAIR, SECOND} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  waddr;
    logic        we;
    logic        is_load;
  } slot_t;

  state_e state_q, state_d;
  slot_t  ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  slot_t  id_a, id_b;
  logic   hz_a, hz_b, load_hazard, pair_dep, id_ready;

  assign id_a = '{valid: bus.ID_valid_a, pc: bus.ID_pc_a,
                  raddr1: bus.ID_rf_raddr_a1, raddr2: bus.ID_rf_raddr_a2,
                  rdata1: bus.ID_rf_rdata_a1, rdata2: bus.ID_rf_rdata_a2,
                  waddr: bus.ID_rf_waddr_a, we: bus.ID_rf_we_a,
                  is_load: bus.ID_is_load_a};
  assign id_b = '{valid: bus.ID_valid_b, pc: bus.ID_pc_b,
                  raddr1: bus.ID_rf_raddr_b1, raddr2: bus.ID_rf_raddr_b2,
                  rdata1: bus.ID_rf_rdata_b1, rdata2: bus.ID_rf_rdata_b2,
                  waddr: bus.ID_rf_waddr_b, we: bus.ID_rf_we_b,
                  is_load: bus.ID_is_load_b};

  // An invalid ID slot issues as a bubble; writes to r0 are never enabled.
  function automatic slot_t issue(slot_t s);
    slot_t r;
    r         = s;
    r.we      = s.valid & s.we & (s.waddr != 5'd0);
    r.is_load = s.valid & s.is_load;
    return r;
  endfunction

  function automatic slot_t bubble(slot_t s);
    slot_t r;
    r         = s;
    r.valid   = 1'b0;
    r.we      = 1'b0;
    r.is_load = 1'b0;
    return r;
  endfunction

  function automatic logic hit_one(logic [4:0] r, slot_t s);
    return (r == s.waddr) & s.we & s.is_load & s.valid;
  endfunction

  function automatic logic src_hit(logic [4:0] r);
    return hit_one(r, ex_a_q) | hit_one(r, ex_b_q);
  endfunction

  assign hz_a = id_a.valid & (src_hit(id_a.raddr1) | src_hit(id_a.raddr2));
  assign hz_b = id_b.valid & (src_hit(id_b.raddr1) | src_hit(id_b.raddr2));
  assign load_hazard = (state_q == PAIR) ? (hz_a | hz_b) : hz_b;

  assign pair_dep = (state_q == PAIR) & id_a.valid & id_b.valid & id_a.we &
                    (id_a.waddr != 5'd0) &
                    ((id_b.raddr1 == id_a.waddr) | (id_b.raddr2 == id_a.waddr));

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    ex_a_d   = ex_a_q;
    ex_b_d   = ex_b_q;
    state_d  = state_q;
    id_ready = 1'b0;
    if (bus.flush) begin
      ex_a_d   = bubble(id_a);
      ex_b_d   = bubble(id_b);
      state_d  = PAIR;
      id_ready = 1'b1;
    end else if (bus.mem_stall) begin
      id_ready = 1'b0;
    end else if (load_hazard) begin
      ex_a_d = bubble(id_a);
      ex_b_d = bubble(id_b);
    end else if (state_q == PAIR && pair_dep) begin
      ex_a_d  = issue(id_a);
      ex_b_d  = bubble(id_b);
      state_d = SECOND;
    end else if (state_q == PAIR) begin
      ex_a_d   = issue(id_a);
      ex_b_d   = issue(id_b);
      id_ready = 1'b1;
    end else begin
      ex_a_d   = bubble(id_a);
      ex_b_d   = issue(id_b);
      state_d  = PAIR;
      id_ready = 1'b1;
    end
  end

  // ID may advance through reset so it restarts from its own reset state.
  assign bus.ID_ready = id_ready | (rst & ~bus.mem_stall);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_a_q  <= '0;
      ex_b_q  <= '0;
      state_q <= PAIR;
    end else begin
      ex_a_q  <= ex_a_d;
      ex_b_q  <= ex_b_d;
      state_q <= state_d;
    end
  end

  assign bus.EX_valid_a     = ex_a_q.valid;
  assign bus.EX_pc_a        = ex_a_q.pc;
  assign bus.EX_rf_raddr_a1 = ex_a_q.raddr1;
  assign bus.EX_rf_raddr_a2 = ex_a_q.raddr2;
  assign bus.EX_rf_rdata_a1 = ex_a_q.rdata1;
  assign bus.EX_rf_rdata_a2 = ex_a_q.rdata2;
  assign bus.EX_rf_waddr_a  = ex_a_q.waddr;
  assign bus.EX_rf_we_a     = ex_a_q.we;
  assign bus.EX_is_load_a   = ex_a_q.is_load;

  assign bus.EX_valid_b     = ex_b_q.valid;
  assign bus.EX_pc_b        = ex_b_q.pc;
  assign bus.EX_rf_raddr_b1 = ex_b_q.raddr1;
  assign bus.EX_rf_raddr_b2 = ex_b_q.raddr2;
  assign bus.EX_rf_rdata_b1 = ex_b_q.rdata1;
  assign bus.EX_rf_rdata_b2 = ex_b_q.rdata2;
  assign bus.EX_rf_waddr_b  = ex_b_q.waddr;
  assign bus.EX_rf_we_b     = ex_b_q.we;
  assign bus.EX_is_load_b   = ex_b_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural pipeline model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if bus ();

  id_ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit [4:0]  ra1, ra2;
    bit [31:0] rd1, rd2;
    bit [4:0]  wa;
    bit        we, ld;
  } slot_t;

  slot_t id_s[2];
  slot_t ex_m[2];
  slot_t nx_m[2];
  bit    m_second, ns_m, rdy_m;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic slot_t mk(bit v, bit [31:0] pc, bit [4:0] ra1, bit [4:0] ra2,
                               bit [31:0] rd1, bit [31:0] rd2, bit [4:0] wa, bit we, bit ld);
    slot_t s;
    s.v = v; s.pc = pc; s.ra1 = ra1; s.ra2 = ra2; s.rd1 = rd1; s.rd2 = rd2;
    s.wa = wa; s.we = we; s.ld = ld;
    return s;
  endfunction

  function automatic slot_t bubbled();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // What EX holds after an instruction issues: write only if real and not r0.
  function automatic slot_t issued(slot_t s);
    slot_t r = s;
    if (!r.v) begin r.we = 0; r.ld = 0; end
    if (r.wa == 5'd0) r.we = 0;
    return r;
  endfunction

  function automatic bit model_hit(bit [4:0] r);
    for (int s = 0; s < 2; s++)
      if (ex_m[s].v && ex_m[s].we && ex_m[s].ld && ex_m[s].wa == r) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    ex_m[0] = bubbled(); ex_m[1] = bubbled(); m_second = 0;
  endfunction

  function automatic void model_eval();
    bit lh = 0;
    bit pd;
    for (int s = 0; s < 2; s++)
      if (id_s[s].v && (s == 1 || !m_second) && (model_hit(id_s[s].ra1) || model_hit(id_s[s].ra2)))
        lh = 1;
    pd = !m_second && id_s[0].v && id_s[1].v && id_s[0].we && id_s[0].wa != 0 &&
         (id_s[1].ra1 == id_s[0].wa || id_s[1].ra2 == id_s[0].wa);
    nx_m = ex_m;
    ns_m = m_second;
    if (rst) begin
      rdy_m = bus.flush || !bus.mem_stall;
      nx_m[0] = bubbled(); nx_m[1] = bubbled(); ns_m = 0;
    end else if (bus.flush) begin
      rdy_m = 1; nx_m[0] = bubbled(); nx_m[1] = bubbled(); ns_m = 0;
    end else if (bus.mem_stall) begin
      rdy_m = 0;
    end else if (lh) begin
      rdy_m = 0; nx_m[0] = bubbled(); nx_m[1] = bubbled();
    end else if (!m_second && pd) begin
      rdy_m = 0; nx_m[0] = issued(id_s[0]); nx_m[1] = bubbled(); ns_m = 1;
    end else if (!m_second) begin
      rdy_m = 1; nx_m[0] = issued(id_s[0]); nx_m[1] = issued(id_s[1]);
    end else begin
      rdy_m = 1; nx_m[0] = bubbled(); nx_m[1] = issued(id_s[1]); ns_m = 0;
    end
  endfunction

  task automatic drive_id(input slot_t a, input slot_t b);
    id_s[0] = a; id_s[1] = b;
    bus.ID_valid_a = a.v;   bus.ID_pc_a = a.pc;
    bus.ID_rf_raddr_a1 = a.ra1; bus.ID_rf_raddr_a2 = a.ra2;
    bus.ID_rf_rdata_a1 = a.rd1; bus.ID_rf_rdata_a2 = a.rd2;
    bus.ID_rf_waddr_a = a.wa; bus.ID_rf_we_a = a.we; bus.ID_is_load_a = a.ld;
    bus.ID_valid_b = b.v;   bus.ID_pc_b = b.pc;
    bus.ID_rf_raddr_b1 = b.ra1; bus.ID_rf_raddr_b2 = b.ra2;
    bus.ID_rf_rdata_b1 = b.rd1; bus.ID_rf_rdata_b2 = b.rd2;
    bus.ID_rf_waddr_b = b.wa; bus.ID_rf_we_b = b.we; bus.ID_is_load_b = b.ld;
  endtask

  task automatic compare_ex();
    check("EX_valid_a", bus.EX_valid_a, ex_m[0].v);
    check("EX_rf_we_a", bus.EX_rf_we_a, ex_m[0].we);
    check("EX_is_load_a", bus.EX_is_load_a, ex_m[0].ld);
    check("EX_valid_b", bus.EX_valid_b, ex_m[1].v);
    check("EX_rf_we_b", bus.EX_rf_we_b, ex_m[1].we);
    check("EX_is_load_b", bus.EX_is_load_b, ex_m[1].ld);
    if (ex_m[0].v) begin
      check("EX_pc_a", bus.EX_pc_a, ex_m[0].pc);
      check("EX_rf_raddr_a1", bus.EX_rf_raddr_a1, ex_m[0].ra1);
      check("EX_rf_raddr_a2", bus.EX_rf_raddr_a2, ex_m[0].ra2);
      check("EX_rf_rdata_a1", bus.EX_rf_rdata_a1, ex_m[0].rd1);
      check("EX_rf_rdata_a2", bus.EX_rf_rdata_a2, ex_m[0].rd2);
      check("EX_rf_waddr_a", bus.EX_rf_waddr_a, ex_m[0].wa);
    end
    if (ex_m[1].v) begin
      check("EX_pc_b", bus.EX_pc_b, ex_m[1].pc);
      check("EX_rf_raddr_b1", bus.EX_rf_raddr_b1, ex_m[1].ra1);
      check("EX_rf_raddr_b2", bus.EX_rf_raddr_b2, ex_m[1].ra2);
      check("EX_rf_rdata_b1", bus.EX_rf_rdata_b1, ex_m[1].rd1);
      check("EX_rf_rdata_b2", bus.EX_rf_rdata_b2, ex_m[1].rd2);
      check("EX_rf_waddr_b", bus.EX_rf_waddr_b, ex_m[1].wa);
    end
  endtask

  // One clock: inputs are already driven; ready checked mid-cycle, EX after the edge.
  task automatic cycle(output bit rdy_seen);
    @(negedge clk);
    model_eval();
    check("ID_ready", bus.ID_ready, rdy_m);
    rdy_seen = bus.ID_ready;
    @(posedge clk);
    ex_m = nx_m;
    m_second = ns_m;
    #1;
    compare_ex();
  endtask

  function automatic slot_t rand_slot();
    return mk($urandom_range(0, 99) < 85, $urandom, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 7)),
              $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 40);
  endfunction

  bit    r;
  slot_t a, b, dep_a, dep_b;

  initial begin
    rst = 1'b1; bus.flush = 1'b0; bus.mem_stall = 1'b0;
    drive_id(bubbled(), bubbled());
    model_reset();

    // Reset state
    cycle(r);
    check("rst_ready", r, 1);
    check("rst_valid_a", bus.EX_valid_a, 0);
    check("rst_valid_b", bus.EX_valid_b, 0);
    check("rst_pc_a", bus.EX_pc_a, 0);
    check("rst_rdata_b2", bus.EX_rf_rdata_b2, 0);
    rst = 1'b0;

    // Independent pair
    drive_id(mk(1, 'h100, 1, 2, 'h11, 'h22, 4, 1, 0), mk(1, 'h104, 6, 3, 'h66, 'h33, 5, 1, 0));
    cycle(r);
    check("indep_ready", r, 1);
    check("indep_valid_a", bus.EX_valid_a, 1);
    check("indep_valid_b", bus.EX_valid_b, 1);
    check("indep_waddr_a", bus.EX_rf_waddr_a, 4);
    check("indep_waddr_b", bus.EX_rf_waddr_b, 5);

    // Intra-pair dependency splits over two cycles
    dep_a = mk(1, 'h108, 1, 2, 'h1, 'h2, 7, 1, 0);
    dep_b = mk(1, 'h10c, 7, 3, 'h7, 'h3, 8, 1, 0);
    drive_id(dep_a, dep_b);
    cycle(r);
    check("dep1_ready", r, 0);
    check("dep1_valid_a", bus.EX_valid_a, 1);
    check("dep1_valid_b", bus.EX_valid_b, 0);
    cycle(r);
    check("dep2_ready", r, 1);
    check("dep2_valid_a", bus.EX_valid_a, 0);
    check("dep2_valid_b", bus.EX_valid_b, 1);
    check("dep2_raddr_b1", bus.EX_rf_raddr_b1, 7);

    // Load-use bubble, then issue with the fresh rdata
    drive_id(mk(1, 'h110, 1, 2, 0, 0, 10, 1, 0), mk(1, 'h114, 3, 4, 0, 0, 9, 1, 1));
    cycle(r);
    a = mk(1, 'h118, 9, 2, 'h1111, 'h5, 11, 1, 0);
    b = mk(1, 'h11c, 3, 4, 'h6, 'h7, 12, 1, 0);
    drive_id(a, b);
    cycle(r);
    check("lu_bubble_ready", r, 0);
    check("lu_bubble_valid_a", bus.EX_valid_a, 0);
    check("lu_bubble_valid_b", bus.EX_valid_b, 0);
    a.rd1 = 'h2222;
    drive_id(a, b);
    cycle(r);
    check("lu_issue_ready", r, 1);
    check("lu_issue_valid_a", bus.EX_valid_a, 1);
    check("lu_issue_rdata_a1", bus.EX_rf_rdata_a1, 'h2222);

    // Load to r0 never interlocks and never enables a write
    drive_id(mk(1, 'h120, 1, 2, 0, 0, 13, 1, 0), mk(1, 'h124, 3, 4, 0, 0, 0, 1, 1));
    cycle(r);
    check("r0_we_b", bus.EX_rf_we_b, 0);
    check("r0_load_b", bus.EX_is_load_b, 1);
    drive_id(mk(1, 'h128, 0, 0, 0, 0, 14, 1, 0), mk(1, 'h12c, 0, 5, 0, 0, 15, 1, 0));
    cycle(r);
    check("r0_ready", r, 1);
    check("r0_valid_a", bus.EX_valid_a, 1);

    // mem_stall holds EX for three cycles
    drive_id(mk(1, 'h130, 1, 2, 'hA, 'hB, 16, 1, 0), mk(1, 'h134, 3, 4, 'hC, 'hD, 17, 1, 0));
    cycle(r);
    bus.mem_stall = 1'b1;
    drive_id(mk(1, 'h140, 1, 2, 0, 0, 18, 1, 0), mk(1, 'h144, 3, 4, 0, 0, 19, 1, 0));
    for (int k = 0; k < 3; k++) begin
      cycle(r);
      check("stall_ready", r, 0);
      check("stall_pc_a", bus.EX_pc_a, 'h130);
      check("stall_pc_b", bus.EX_pc_b, 'h134);
      check("stall_rdata_b2", bus.EX_rf_rdata_b2, 'hD);
    end
    bus.mem_stall = 1'b0;
    cycle(r);
    check("unstall_ready", r, 1);
    check("unstall_pc_a", bus.EX_pc_a, 'h140);

    // Flush + mem_stall while in SECOND
    dep_a.pc = 'h150; dep_b.pc = 'h154;
    drive_id(dep_a, dep_b);
    cycle(r);
    bus.flush = 1'b1; bus.mem_stall = 1'b1;
    cycle(r);
    check("flush_ready", r, 1);
    check("flush_valid_a", bus.EX_valid_a, 0);
    check("flush_valid_b", bus.EX_valid_b, 0);
    bus.flush = 1'b0; bus.mem_stall = 1'b0;
    cycle(r);
    check("post_flush_pair_ready", r, 0);
    check("post_flush_valid_a", bus.EX_valid_a, 1);

    // Async reset mid-cycle while slot b is pending
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("async_valid_a", bus.EX_valid_a, 0);
    check("async_valid_b", bus.EX_valid_b, 0);
    rst = 1'b0;
    drive_id(mk(1, 'h160, 1, 2, 0, 0, 20, 1, 0), mk(1, 'h164, 3, 4, 0, 0, 21, 1, 0));
    cycle(r);
    check("after_rst_valid_a", bus.EX_valid_a, 1);
    check("after_rst_valid_b", bus.EX_valid_b, 1);

    // Randomized traffic; ID holds all but rdata while not ready
    r = 1;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (rst) model_reset();
      bus.flush     = ($urandom_range(0, 99) < 6);
      bus.mem_stall = ($urandom_range(0, 99) < 25);
      if (!rdy_m && !rst) begin
        a = id_s[0]; b = id_s[1];
        a.rd1 = $urandom; a.rd2 = $urandom; b.rd1 = $urandom; b.rd2 = $urandom;
      end else begin
        a = rand_slot(); b = rand_slot();
      end
      drive_id(a, b);
      cycle(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first; one clock; reset is asynchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  branch redirect from EX; kill EX contents
- mem_stall  in  1  backend stall; freeze this stage
- ID_valid_a / ID_valid_b  in  1  decoded slot valid
- ID_pc_a / ID_pc_b  in  32  slot PC
- ID_rf_raddr_{a1,a2,b1,b2}  in  5  source register addresses
- ID_rf_rdata_{a1,a2,b1,b2}  in  32  register-file read data; the register file is write-through, so same-cycle WB writes are visible
- ID_rf_waddr_a / ID_rf_waddr_b  in  5  destination register
- ID_rf_we_a / ID_rf_we_b  in  1  destination write enable
- ID_is_load_a / ID_is_load_b  in  1  slot is a memory load
- ID_ready  out  1  ID pair consumed this cycle; ID advances
- EX_valid_a / EX_valid_b  out  1  registered slot valid
- EX_pc_a / EX_pc_b  out  32  registered PC
- EX_rf_raddr_{a1,a2,b1,b2}  out  5  registered sources; feed EX forwarding
- EX_rf_rdata_{a1,a2,b1,b2}  out  32  registered operands; feed EX forwarding
- EX_rf_waddr_a / EX_rf_waddr_b  out  5  registered destination
- EX_rf_we_a / EX_rf_we_b  out  1  registered write enable
- EX_is_load_a / EX_is_load_b  out  1  registered load flag

Function
REQ-002 SHALL register every EX_* output on the rising edge of clk; latency ID->EX is 1 cycle.
REQ-003 SHALL latch EX_rf_we_x as ID_rf_we_x & (ID_rf_waddr_x != 0) & slot issued.
REQ-004 A bubbled slot SHALL have EX_valid=0, EX_rf_we=0 and EX_is_load=0; its other fields are don't-care.
REQ-005 SHALL define src_hit(r) = (r == EX_rf_waddr_s) & EX_rf_we_s & EX_is_load_s & EX_valid_s, for either EX slot s.
REQ-006 load_hazard SHALL be asserted when any source of a considered ID slot hits (REQ-005). The considered slots are each valid ID slot in state PAIR, and only slot b in state SECOND.
REQ-007 pair_dep SHALL be asserted in state PAIR when ID_valid_a & ID_valid_b & ID_rf_we_a & ID_rf_waddr_a != 0 & (ID_rf_raddr_b1 or ID_rf_raddr_b2 equals ID_rf_waddr_a).
REQ-008 The FSM SHALL have two states:
- PAIR: both ID slots eligible.
- SECOND: slot a has already issued; slot b is pending.
REQ-009 The per-cycle action SHALL follow this priority:
- flush: both EX slots bubbled; state -> PAIR; ID_ready=1.
- else mem_stall: all EX registers hold; state holds; ID_ready=0.
- else load_hazard: both EX slots bubbled; state holds; ID_ready=0.
- else PAIR & pair_dep: issue slot a only, slot b bubbled; state -> SECOND; ID_ready=0.
- else PAIR: issue both ID slots as-is; ID_ready=1.
- else SECOND: issue ID slot b into EX slot b, EX slot a bubbled; state -> PAIR; ID_ready=1.
REQ-010 ID_ready SHALL be combinational from the current state and inputs.
REQ-011 While ID_ready=0, ID SHALL hold its inputs stable. The block SHALL still capture the current-cycle ID_rf_rdata, never a stale copy.
REQ-012 When an ID slot is invalid, it SHALL propagate as a bubble and never trigger load_hazard or pair_dep.
REQ-013 Cross-slot write-after-write (ID_rf_waddr_a == ID_rf_waddr_b, both we) SHALL issue as a pair. Slot b is younger, and EX forwarding gives slot b priority.
REQ-014 flush asserted together with mem_stall SHALL bubble EX (flush wins).

Reset
REQ-015 While rst=1, EX_valid_*, EX_rf_we_*, EX_is_load_* SHALL be 0 and state SHALL be PAIR; all other EX_* registers SHALL be 0.
REQ-016 ID_ready SHALL be 1 during reset when mem_stall=0.
REQ-017 Reset asserted mid-SECOND SHALL discard the pending slot b; ID re-presents from its own reset.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Independent pair: add r4 (a) and add r5 (b, reads r6) -> next cycle EX_valid_a=1, EX_valid_b=1, EX_rf_waddr_a=4, EX_rf_waddr_b=5; ID_ready=1.
- Intra-pair dependency: a writes r7, b reads r7 -> cycle 1: EX_valid_a=1, EX_valid_b=0, ID_ready=0. Cycle 2: EX_valid_a=0, EX_valid_b=1, EX_rf_raddr_b1=7, ID_ready=1.
- Load-use: EX slot b is a valid load writing r9, ID slot a reads r9 -> one bubble cycle (EX_valid_a=0, EX_valid_b=0, ID_ready=0). Then the pair issues with the rdata presented that cycle.
- Load writing r0 in EX and ID reading r0 -> no bubble; EX_rf_we=0 for any waddr=0.
- mem_stall held 3 cycles with a pair in EX -> EX outputs unchanged bit-for-bit; ID_ready=0 for all 3 cycles.
- Flush in SECOND state, with mem_stall=1 in the same cycle -> EX_valid_a=0, EX_valid_b=0 next cycle, state=PAIR; then async rst pulse mid-cycle -> EX_valid_* drop immediately to 0 without waiting for a clock edge.
